divider: RTL and testbench

//   Multi-cycle signed/unsigned integer divider used by the EX stage for DIV/DIVU.

---
 rtl/divider.sv | 115 +++++++++++
 tb/tb_divider.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Multi-cycle restoring divider for DIV/DIVU; result is {remainder, quotient}.
// Requests a pipeline stall while busy and abandons the operation on annul.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               signed_div_input,
    input  logic [WIDTH-1:0]   operand_a_input,
    input  logic [WIDTH-1:0]   operand_b_input,
    input  logic               start_input,
    input  logic               annul_input,
    output logic [2*WIDTH-1:0] result_output,
    output logic               ready_output,
    output logic               stop_req_output
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BY_ZERO, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_shift, diff;
    logic [WIDTH-1:0] quo_next, rem_next, quo_fix, rem_fix;

    // The stored remainder is always below the divisor, so WIDTH bits suffice;
    // only the shifted working value needs the extra bit.
    always_comb begin
        a_neg     = signed_div_input & operand_a_input[WIDTH-1];
        b_neg     = signed_div_input & operand_b_input[WIDTH-1];
        a_mag     = a_neg ? -operand_a_input : operand_a_input;
        b_mag     = b_neg ? -operand_b_input : operand_b_input;
        rem_shift = {rem, quo[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvs};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
        quo_fix = neg_q ? -quo_next : quo_next;
        rem_fix = neg_r ? -rem_next : rem_next;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            counter       <= '0;
            quo           <= '0;
            rem           <= '0;
            dvs           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            ready_output  <= 1'b0;
            result_output <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_input && !annul_input) begin
                        quo     <= a_mag;
                        rem     <= '0;
                        dvs     <= b_mag;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        counter <= '0;
                        state   <= (operand_b_input == '0) ? BY_ZERO : RUN;
                    end
                end
                BY_ZERO: begin
                    state         <= DONE;
                    ready_output  <= 1'b1;
                    result_output <= '0;
                end
                RUN: begin
                    // Abort beats completion of the final step.
                    if (annul_input || !start_input) begin
                        state         <= IDLE;
                        ready_output  <= 1'b0;
                        result_output <= '0;
                    end else begin
                        quo     <= quo_next;
                        rem     <= rem_next;
                        counter <= counter + 1'b1;
                        if (counter == CW'(WIDTH - 1)) begin
                            state         <= DONE;
                            ready_output  <= 1'b1;
                            result_output <= {rem_fix, quo_fix};
                        end
                    end
                end
                DONE: begin
                    if (!start_input || annul_input) begin
                        state         <= IDLE;
                        ready_output  <= 1'b0;
                        result_output <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stop_req_output = start_input & ~ready_output;

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: arithmetic model from plain 64-bit division,
// per-cycle output checker, and literal results/latencies per vector.
module tb_divider;

    logic        clock;
    logic        reset;
    logic        signed_div_input;
    logic [31:0] operand_a_input;
    logic [31:0] operand_b_input;
    logic        start_input;
    logic        annul_input;
    logic [63:0] result_output;
    logic        ready_output;
    logic        stop_req_output;

    int          n_cmp;
    int          n_fail;
    logic        chk_en;
    logic [63:0] exp_res;

    divider #(.WIDTH(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .signed_div_input(signed_div_input),
        .operand_a_input (operand_a_input),
        .operand_b_input (operand_b_input),
        .start_input     (start_input),
        .annul_input     (annul_input),
        .result_output   (result_output),
        .ready_output    (ready_output),
        .stop_req_output (stop_req_output)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Truncating division done in 64 bits so MIN / -1 simply wraps on truncation.
    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Every cycle: stall request rule, and result either the model's value or zero.
    always @(negedge clock) begin
        if (chk_en) begin
            check("stop_req_rule", {63'd0, stop_req_output},
                  {63'd0, start_input & ~ready_output});
            if (ready_output === 1'b1)
                check("result_model", result_output, exp_res);
            else
                check("result_idle_zero", result_output, 64'd0);
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string name, output int lat);
        lat = 0;
        forever begin
            @(negedge clock);
            if (ready_output === 1'b1) return;
            check({name, "_stall_high"}, {63'd0, stop_req_output}, 64'd1);
            if (lat >= 100) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s_timeout: ready not seen after %0d cycles", name, lat);
                return;
            end
            next_cycle();
            lat++;
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        operand_a_input  = a;
        operand_b_input  = b;
        signed_div_input = sgn;
        exp_res          = model_div(a, b, sgn);
        start_input      = 1'b1;
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input int exp_lat, input logic [63:0] lit);
        int lat;
        launch(a, b, sgn);
        wait_ready(name, lat);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_result"}, result_output, lit);
        check({name, "_stall_low"}, {63'd0, stop_req_output}, 64'd0);
        // Operands change after acceptance; result must not move.
        operand_a_input = ~a;
        operand_b_input = 32'd0;
        next_cycle();
        start_input = 1'b0;
        next_cycle();
        @(negedge clock);
        check({name, "_ready_drop"}, {63'd0, ready_output}, 64'd0);
        next_cycle();
    endtask

    initial begin
        n_cmp            = 0;
        n_fail           = 0;
        chk_en           = 1'b0;
        exp_res          = 64'd0;
        reset            = 1'b0;
        start_input      = 1'b0;
        annul_input      = 1'b0;
        signed_div_input = 1'b0;
        operand_a_input  = 32'd0;
        operand_b_input  = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;
        @(negedge clock);
        check("reset_ready", {63'd0, ready_output}, 64'd0);
        check("reset_result", result_output, 64'd0);
        check("reset_stall", {63'd0, stop_req_output}, 64'd0);
        next_cycle();

        run_op("udiv_100_7",   32'd100,        32'd7,          1'b0, 33, {32'd2, 32'd14});
        run_op("sdiv_m7_2",    32'hFFFFFFF9,   32'h2,          1'b1, 33, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op("udiv_m7_2",    32'hFFFFFFF9,   32'h2,          1'b0, 33, {32'd1, 32'h7FFFFFFC});
        run_op("sdiv_7_m2",    32'd7,          32'hFFFFFFFE,   1'b1, 33, {32'd1, 32'hFFFFFFFD});
        run_op("udiv_max_1",   32'hFFFFFFFF,   32'd1,          1'b0, 33, {32'd0, 32'hFFFFFFFF});
        run_op("sdiv_min_m1",  32'h80000000,   32'hFFFFFFFF,   1'b1, 33, {32'd0, 32'h80000000});

        // Divide by zero: ready in cycle 2, held while start stays high.
        begin
            int lat;
            launch(32'd5, 32'd0, 1'b0);
            wait_ready("div0", lat);
            check("div0_latency", 64'(lat), 64'd2);
            check("div0_result", result_output, 64'd0);
            for (int i = 0; i < 3; i++) begin
                next_cycle();
                @(negedge clock);
                check("div0_hold_ready", {63'd0, ready_output}, 64'd1);
            end
            next_cycle();
            start_input = 1'b0;
            @(negedge clock);
            check("div0_ready_same_cycle", {63'd0, ready_output}, 64'd1);
            next_cycle();
            @(negedge clock);
            check("div0_ready_drop", {63'd0, ready_output}, 64'd0);
            next_cycle();
        end

        // Annul in cycle 10; the next cycle starts a fresh 9/3 as its cycle 0.
        begin
            int lat;
            launch(32'd100, 32'd7, 1'b0);
            for (int i = 0; i < 10; i++) begin
                @(negedge clock);
                check("annul_busy", {63'd0, ready_output}, 64'd0);
                next_cycle();
            end
            annul_input = 1'b1;
            next_cycle();
            annul_input = 1'b0;
            launch(32'd9, 32'd3, 1'b0);
            wait_ready("after_annul", lat);
            check("after_annul_latency", 64'(lat), 64'd33);
            check("after_annul_result", result_output, {32'd0, 32'd3});
            next_cycle();
            start_input = 1'b0;
            next_cycle();
            next_cycle();
        end

        // Reset in cycle 20 of a run aborts it; a following op sees full latency.
        begin
            launch(32'd1000, 32'd10, 1'b0);
            repeat (20) next_cycle();
            reset = 1'b0;
            @(negedge clock);
            check("rst_mid_stall_follows_start", {63'd0, stop_req_output}, 64'd1);
            next_cycle();
            reset       = 1'b1;
            start_input = 1'b0;
            @(negedge clock);
            check("rst_mid_ready", {63'd0, ready_output}, 64'd0);
            check("rst_mid_result", result_output, 64'd0);
            check("rst_mid_stall_low", {63'd0, stop_req_output}, 64'd0);
            next_cycle();
            run_op("after_reset", 32'd1000, 32'd10, 1'b0, 33, {32'd0, 32'd100});
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
